monitor_core_mc: RTL and testbench

Multi-channel successor to the single-patient post-op system-core FSM. It arbitrates status, history, level-sum, change and alarm requests from NCH monitored channels (beds) and drives one shared set of Moore enables plus a channel select toward the datapath. Over the single-channel core it adds:
- per-channel alarm latching with operator acknowledge;
- round-robin fairness;
- a bounded service time;
- a full-channel change sweep on the 24 h clear.

---
 rtl/monitor_core_mc.sv | 198 +++++++++++++++++++
 tb/tb_monitor_core_mc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_core_mc.sv
// Multi-channel post-op monitor core: arbitrates per-bed requests/alarms into one Moore enable set + ch_sel.
// Latency: request sampled in POST_OP gives its enable from the same edge; alarm_in -> alarm_pend 1 cycle.
// Backpressure: none; a service state holds while its request is held, bounded by MAXSVC cycles.
//
// Ports:
//   clk, rst (async, active-low)          clock and reset
//   sw, clear                             monitoring enable, 24 h clear (rising edge acts)
//   status_req/history_req/lev_req/change_req/alarm_in [NCH]   per-channel requests/alarms
//   alarm_ack                             operator acknowledge of the displayed alarm
//   fwait, enhours, enalarm, enlev, enchange, enstatus, enhist  registered Moore enables
//   ch_sel [CHW]                          channel served by current state
//   alarm_pend [NCH]                      latched unacknowledged alarms
module monitor_core_mc #(
  parameter int NCH    = 4,
  parameter int CHW    = 2,
  parameter int MAXSVC = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sw,
  input  logic           clear,
  input  logic [NCH-1:0] status_req,
  input  logic [NCH-1:0] history_req,
  input  logic [NCH-1:0] lev_req,
  input  logic [NCH-1:0] change_req,
  input  logic [NCH-1:0] alarm_in,
  input  logic           alarm_ack,
  output logic           fwait,
  output logic           enhours,
  output logic           enalarm,
  output logic           enlev,
  output logic           enchange,
  output logic           enstatus,
  output logic           enhist,
  output logic [CHW-1:0] ch_sel,
  output logic [NCH-1:0] alarm_pend
);

  typedef enum logic [2:0] {
    IDLE, POST_OP, SOMMA, STATUS, HISTORY, CHANGE, ALARM
  } state_e;

  state_e           state_q, state_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [CHW-1:0]   last_q, last_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [7:0]       svc_q, svc_d;
  logic             clear_q;
  logic             sweep_q, sweep_d;
  logic [6:0]       en_q, en_d;

  logic             clr_edge;
  logic             svc_req;
  logic             stay;
  logic [NCH-1:0]   ack_mask;
  logic [CHW:0]     p_alarm, p_other, p_chg, p_lev, p_stat, p_hist;

  // Round-robin pick: {found, channel}. Scanning from the farthest candidate
  // down to last+1 lets the nearest requester overwrite the result.
  function automatic logic [CHW:0] rr_pick(input logic [NCH-1:0] req,
                                           input logic [CHW-1:0] last);
    logic [CHW:0] r;
    int           idx;
    r = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = (int'(last) + i) % NCH;
      if (req[idx]) r = {1'b1, CHW'(idx)};
    end
    return r;
  endfunction

  assign clr_edge = clear & ~clear_q;
  assign ack_mask = (state_q == ALARM && alarm_ack) ? (NCH'(1) << ch_q) : '0;
  // Set wins over acknowledge on the same bit.
  assign pend_d   = (pend_q & ~ack_mask) | alarm_in;

  assign p_alarm  = rr_pick(pend_q, last_q);
  assign p_other  = rr_pick(pend_q & ~ack_mask, last_q);
  assign p_chg    = rr_pick(change_req, last_q);
  assign p_lev    = rr_pick(lev_req, last_q);
  assign p_stat   = rr_pick(status_req, last_q);
  assign p_hist   = rr_pick(history_req, last_q);

  always_comb begin
    svc_req = 1'b0;
    case (state_q)
      SOMMA:   svc_req = lev_req[ch_q];
      STATUS:  svc_req = status_req[ch_q];
      HISTORY: svc_req = history_req[ch_q];
      CHANGE:  svc_req = change_req[ch_q];
      default: svc_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    sweep_d = sweep_q;
    stay    = 1'b0;
    if (!sw) begin
      state_d = IDLE;
      sweep_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = POST_OP;
        POST_OP: begin
          if (clr_edge) begin
            state_d = CHANGE; sweep_d = 1'b1; ch_d = '0;
          end else if (p_alarm[CHW]) begin
            state_d = ALARM;   ch_d = p_alarm[CHW-1:0]; last_d = p_alarm[CHW-1:0];
          end else if (p_chg[CHW]) begin
            state_d = CHANGE;  ch_d = p_chg[CHW-1:0];   last_d = p_chg[CHW-1:0];
          end else if (p_lev[CHW]) begin
            state_d = SOMMA;   ch_d = p_lev[CHW-1:0];   last_d = p_lev[CHW-1:0];
          end else if (p_stat[CHW]) begin
            state_d = STATUS;  ch_d = p_stat[CHW-1:0];  last_d = p_stat[CHW-1:0];
          end else if (p_hist[CHW]) begin
            state_d = HISTORY; ch_d = p_hist[CHW-1:0];  last_d = p_hist[CHW-1:0];
          end
        end
        SOMMA, STATUS, HISTORY, CHANGE: begin
          if (state_q == CHANGE && sweep_q) begin
            // Sweep walks every channel once; clears and alarms wait.
            if (ch_q == CHW'(NCH-1)) begin
              state_d = POST_OP; sweep_d = 1'b0;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else if (clr_edge) begin
            state_d = CHANGE; sweep_d = 1'b1; ch_d = '0;
          end else if (p_alarm[CHW]) begin
            state_d = ALARM; ch_d = p_alarm[CHW-1:0]; last_d = p_alarm[CHW-1:0];
          end else if (!svc_req || svc_q == 8'(MAXSVC-1)) begin
            state_d = POST_OP;
          end else begin
            stay = 1'b1;
          end
        end
        ALARM: begin
          if (clr_edge) begin
            state_d = CHANGE; sweep_d = 1'b1; ch_d = '0;
          end else if (alarm_ack) begin
            if (p_other[CHW]) begin
              ch_d = p_other[CHW-1:0]; last_d = p_other[CHW-1:0];
            end else begin
              state_d = POST_OP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    svc_d = stay ? svc_q + 8'd1 : 8'd0;
  end

  // Enables are registered from the next state so they track state_q exactly.
  always_comb begin
    en_d = '0;
    case (state_d)
      IDLE:    en_d = 7'b1000000;
      POST_OP: en_d = 7'b0100000;
      ALARM:   en_d = 7'b0110000;
      SOMMA:   en_d = 7'b0101000;
      CHANGE:  en_d = 7'b0100100;
      STATUS:  en_d = 7'b0100010;
      HISTORY: en_d = 7'b0100001;
      default: en_d = 7'b1000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      last_q  <= CHW'(NCH-1);
      pend_q  <= '0;
      svc_q   <= '0;
      clear_q <= 1'b0;
      sweep_q <= 1'b0;
      en_q    <= 7'b1000000;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      svc_q   <= svc_d;
      clear_q <= clear;
      sweep_q <= sweep_d;
      en_q    <= en_d;
    end
  end

  assign {fwait, enhours, enalarm, enlev, enchange, enstatus, enhist} = en_q;
  assign ch_sel     = ch_q;
  assign alarm_pend = pend_q;

endmodule

// File: tb/tb_monitor_core_mc.sv
// Directed bench for monitor_core_mc with a tagged scoreboard.
// Stimulus pushes the expected outputs for a given cycle; a negedge monitor pops and compares.
// No backpressure; every expectation carries the cycle it must appear in.
module tb_monitor_core_mc;

  localparam int S_IDLE = 0, S_POST = 1, S_SOMMA = 2, S_STAT = 3,
                 S_HIST = 4, S_CHG = 5, S_ALARM = 6;

  logic       clk = 1'b0;
  logic       rst, sw, clear, alarm_ack;
  logic [3:0] status_req, history_req, lev_req, change_req, alarm_in;
  logic       fwait, enhours, enalarm, enlev, enchange, enstatus, enhist;
  logic [1:0] ch_sel;
  logic [3:0] alarm_pend;

  monitor_core_mc #(.NCH(4), .CHW(2), .MAXSVC(64)) dut (
    .clk(clk), .rst(rst), .sw(sw), .clear(clear),
    .status_req(status_req), .history_req(history_req),
    .lev_req(lev_req), .change_req(change_req),
    .alarm_in(alarm_in), .alarm_ack(alarm_ack),
    .fwait(fwait), .enhours(enhours), .enalarm(enalarm), .enlev(enlev),
    .enchange(enchange), .enstatus(enstatus), .enhist(enhist),
    .ch_sel(ch_sel), .alarm_pend(alarm_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    string       nm;
    logic [12:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] mk(input int st, input int ch, input logic [3:0] pd);
    logic [6:0] en;
    case (st)
      S_IDLE:  en = 7'b1000000;
      S_POST:  en = 7'b0100000;
      S_ALARM: en = 7'b0110000;
      S_SOMMA: en = 7'b0101000;
      S_CHG:   en = 7'b0100100;
      S_STAT:  en = 7'b0100010;
      S_HIST:  en = 7'b0100001;
      default: en = 7'b0000000;
    endcase
    return {en, 2'(ch), pd};
  endfunction

  // Monitor: compares whenever the head entry's cycle comes due.
  always @(negedge clk) begin
    logic [12:0] act;
    act = {fwait, enhours, enalarm, enlev, enchange, enstatus, enhist, ch_sel, alarm_pend};
    if (sb.size() > 0 && sb[0].tag <= cyc) begin
      mon_e = sb.pop_front();
      vectors++;
      if (mon_e.tag != cyc || act !== mon_e.v) begin
        fails++;
        $display("FAIL %s cyc=%0d: got en=%b ch=%0d pend=%b, want en=%b ch=%0d pend=%b (due cyc %0d)",
                 mon_e.nm, cyc, act[12:6], act[5:4], act[3:0],
                 mon_e.v[12:6], mon_e.v[5:4], mon_e.v[3:0], mon_e.tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect the given outputs after the next rising edge, then advance.
  task automatic cx(input string nm, input int st, input int ch, input logic [3:0] pd);
    exp_t e;
    e.tag = cyc + 1;
    e.nm  = nm;
    e.v   = mk(st, ch, pd);
    sb.push_back(e);
    tick();
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; sw = 1'b0; clear = 1'b0; alarm_ack = 1'b0;
    status_req = '0; history_req = '0; lev_req = '0; change_req = '0; alarm_in = '0;
    tick();
    cx("reset", S_IDLE, 0, 4'b0000);
    rst = 1'b1;
    cx("idle_sw0", S_IDLE, 0, 4'b0000);
    sw = 1'b1;
    cx("post_op", S_POST, 0, 4'b0000);
    vectors++;
    if (enhours !== 1'b1 || fwait !== 1'b0) begin
      fails++;
      $display("FAIL direct_post_op: enhours=%b fwait=%b", enhours, fwait);
    end

    // Round-robin level-sum: last=3 -> ch1, then ch3.
    lev_req = 4'b1010;
    cx("somma_ch1", S_SOMMA, 1, 4'b0000);
    cx("somma_ch1_hold", S_SOMMA, 1, 4'b0000);
    lev_req = 4'b1000;
    cx("somma_drop", S_POST, 1, 4'b0000);
    cx("somma_ch3", S_SOMMA, 3, 4'b0000);
    cx("somma_ch3_hold", S_SOMMA, 3, 4'b0000);

    // Alarms on ch0 and ch3 during SOMMA.
    alarm_in = 4'b1001;
    cx("alarm_latch", S_SOMMA, 3, 4'b1001);
    alarm_in = 4'b0000;
    cx("alarm_ch0", S_ALARM, 0, 4'b1001);
    lev_req = 4'b0000;
    cx("alarm_ch0_hold", S_ALARM, 0, 4'b1001);
    alarm_ack = 1'b1;
    cx("alarm_ch3", S_ALARM, 3, 4'b1000);
    cx("alarm_done", S_POST, 3, 4'b0000);
    vectors++;
    if (alarm_pend !== 4'b0000) begin
      fails++;
      $display("FAIL direct_alarm_done: alarm_pend=%b", alarm_pend);
    end
    alarm_ack = 1'b0;
    cx("post_quiet", S_POST, 3, 4'b0000);

    // Status held past the service bound.
    status_req = 4'b0100;
    for (int i = 0; i < 64; i++) cx($sformatf("status_svc%0d", i), S_STAT, 2, 4'b0000);
    cx("status_timeout", S_POST, 2, 4'b0000);
    cx("status_regrant", S_STAT, 2, 4'b0000);
    status_req = 4'b0000;
    cx("status_drop", S_POST, 2, 4'b0000);

    // Clear edge while in ALARM ch1 -> sweep, then back to the alarm.
    alarm_in = 4'b0010;
    cx("alarm1_latch", S_POST, 2, 4'b0010);
    alarm_in = 4'b0000;
    cx("alarm_ch1", S_ALARM, 1, 4'b0010);
    clear = 1'b1;
    cx("sweep0", S_CHG, 0, 4'b0010);
    clear = 1'b0;
    cx("sweep1", S_CHG, 1, 4'b0010);
    clear = 1'b1;
    cx("sweep2_edge_ignored", S_CHG, 2, 4'b0010);
    cx("sweep3", S_CHG, 3, 4'b0010);
    cx("sweep_end", S_POST, 3, 4'b0010);
    cx("alarm_ch1_again", S_ALARM, 1, 4'b0010);
    clear = 1'b0;
    alarm_ack = 1'b1;
    cx("alarm_ch1_ack", S_POST, 1, 4'b0000);
    alarm_ack = 1'b0;

    // History then sw drop with a fresh alarm on ch2.
    history_req = 4'b0001;
    cx("hist_ch0", S_HIST, 0, 4'b0000);
    cx("hist_ch0_hold", S_HIST, 0, 4'b0000);
    sw = 1'b0;
    alarm_in = 4'b0100;
    cx("sw_drop", S_IDLE, 0, 4'b0100);
    alarm_in = 4'b0000;
    history_req = 4'b0000;
    cx("idle_pend_kept", S_IDLE, 0, 4'b0100);
    vectors++;
    if (alarm_pend !== 4'b0100 || fwait !== 1'b1) begin
      fails++;
      $display("FAIL direct_idle_pend: alarm_pend=%b fwait=%b", alarm_pend, fwait);
    end
    sw = 1'b1;
    cx("resume", S_POST, 0, 4'b0100);
    cx("alarm_ch2", S_ALARM, 2, 4'b0100);
    alarm_ack = 1'b1;
    cx("alarm_ch2_ack", S_POST, 2, 4'b0000);
    alarm_ack = 1'b0;

    // Single change then asynchronous reset mid-cycle.
    change_req = 4'b1000;
    cx("change_ch3", S_CHG, 3, 4'b0000);
    e.tag = cyc + 1;
    e.nm  = "async_reset";
    e.v   = mk(S_IDLE, 0, 4'b0000);
    sb.push_back(e);
    tick();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({fwait, enhours, enalarm, enlev, enchange, enstatus, enhist, ch_sel, alarm_pend}
        !== mk(S_IDLE, 0, 4'b0000)) begin
      fails++;
      $display("FAIL direct_async_reset: en=%b ch=%0d pend=%b",
               {fwait, enhours, enalarm, enlev, enchange, enstatus, enhist}, ch_sel, alarm_pend);
    end
    tick();
    change_req = 4'b0000;
    rst = 1'b1;
    tick();
    tick();

    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      fails++;
      $display("FAIL %s: never compared, due cyc %0d, now cyc %0d", e.nm, e.tag, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: run exceeded time limit at cyc %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
